bomb_scheduler: RTL and testbench
=================================

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 Parameter NSLOT, default 4, number of shared bomb slots (2..8).
REQ-002 Parameter FUSE_TICKS, default 3, ticks from grant to blast (1..15).
REQ-003 Parameter BLAST_TICKS, default 2, ticks a blast stays live (1..15).
REQ-004 Parameter MAXPER, default 2, max live bombs per player (1..NSLOT).
REQ-005 clk  in  1  system clock; sole clock.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 tick  in  1  game-time enable, one-cycle pulse.
REQ-008 reqA, reqB  in  1  placement request, level, sampled every cycle.
REQ-009 hA, vA, hB, vB  in  4 each  requesting player's tile coordinates.
REQ-010 grantA, grantB  out  1  one-cycle pulse: request accepted.
REQ-011 denyA, denyB  out  1  one-cycle pulse: request rejected.
REQ-012 aCount, bCount  out  4  live bombs (ARMED or BLAST) owned per player.
REQ-013 blastValid  out  1  one-cycle pulse reporting one newly exploded bomb.
REQ-014 blastH, blastV  out  4 each  tile of the reported blast; blastOwner  out  1  0=A, 1=B.
REQ-015 liveMask  out  NSLOT  bit i set while slot i is in BLAST.

Function
REQ-016 Each slot SHALL hold state IDLE/ARMED/BLAST, owner, h, v, and a 4-bit counter.
REQ-017 A request SHALL be evaluated in the cycle it is high; grant/deny SHALL be registered, appearing exactly one cycle later.
REQ-018 A request SHALL be denied if owner count >= MAXPER, no IDLE slot exists, or any non-IDLE slot holds the same (h,v).
REQ-019 A granted bomb SHALL occupy the lowest-index IDLE slot: ARMED, counter=FUSE_TICKS, owner count +1.
REQ-020 When both players request in one cycle, the priority player SHALL be evaluated first; the other SHALL then be evaluated against state including the first grant (same tile or last slot -> deny).
REQ-021 Priority SHALL start at A and toggle only after a cycle in which both requested.
REQ-022 A player holding req high SHALL receive a grant or deny every cycle; upstream supplies single-cycle requests.
REQ-023 On tick, every ARMED slot SHALL decrement; at counter 1 it SHALL enter BLAST with counter=BLAST_TICKS and set its pending-report flag.
REQ-024 On tick, every BLAST slot SHALL decrement; at counter 1 it SHALL become IDLE and decrement owner count.
REQ-025 A slot freed this cycle SHALL NOT be allocatable, nor its count decrement visible to REQ-018, until the next cycle.
REQ-026 A grant and a free for the same owner in one cycle SHALL leave the count unchanged.
REQ-027 Each cycle, the lowest-index slot with pending flag set SHALL drive blastValid/H/V/Owner for one cycle and clear its flag; simultaneous blasts are serialized in index order.
REQ-028 A slot reaching IDLE with pending flag still set SHALL still be reported; the flag clears only on report.
REQ-029 Counts SHALL never exceed MAXPER nor underflow.

Reset
REQ-030 While rst is low: all slots IDLE, counters 0, pending flags 0, priority=A, all outputs 0.
REQ-031 Reset asserted mid-fuse or mid-blast SHALL discard all bombs; no blast reported after release.

Verification
REQ-032 reqA at (2,3), then 3 ticks -> grantA next cycle, aCount=1; blastValid (2,3) owner 0 one cycle after 3rd tick; 2 more ticks -> aCount=0.
REQ-033 reqA and reqB same cycle, tile (4,1) -> grantA+denyB; repeat with tile (5,1) -> grantB+denyA (priority toggled).
REQ-034 A places 2 bombs, third request -> denyA, aCount=2; B still granted.
REQ-035 4 bombs granted on one tick phase -> 4 blastValid pulses on consecutive cycles, slot order 0..3; 5th request before expiry -> deny.
REQ-036 rst low for 1 cycle with 2 ARMED bombs -> counts 0, no blastValid on following ticks.

Source files
------------

// File: rtl/bomb_scheduler.sv
// Shared bomb-slot scheduler for two players: arbitrates placement requests,
// runs fuse/blast countdowns on game ticks and serializes blast reports.
module bomb_scheduler #(
  parameter int NSLOT       = 4,
  parameter int FUSE_TICKS  = 3,
  parameter int BLAST_TICKS = 2,
  parameter int MAXPER      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             reqA,
  input  logic             reqB,
  input  logic [3:0]       hA,
  input  logic [3:0]       vA,
  input  logic [3:0]       hB,
  input  logic [3:0]       vB,
  output logic             grantA,
  output logic             grantB,
  output logic             denyA,
  output logic             denyB,
  output logic [3:0]       aCount,
  output logic [3:0]       bCount,
  output logic             blastValid,
  output logic [3:0]       blastH,
  output logic [3:0]       blastV,
  output logic             blastOwner,
  output logic [NSLOT-1:0] liveMask
);

  localparam int         SW         = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [3:0] FUSE_INIT  = 4'(FUSE_TICKS);
  localparam logic [3:0] BLAST_INIT = 4'(BLAST_TICKS);
  localparam logic [3:0] MAXC       = 4'(MAXPER);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BLAST = 2'd2} slotState_t;

  slotState_t       slotState [NSLOT];
  logic [3:0]       slotH     [NSLOT];
  logic [3:0]       slotV     [NSLOT];
  logic [3:0]       slotCnt   [NSLOT];
  logic [NSLOT-1:0] slotOwner;
  logic [NSLOT-1:0] pend;
  logic             prioB;

  logic [NSLOT-1:0] idleMask, idle2, newBlast, freeMask, candMask;
  logic             firstReq, secondReq, firstOk, secondOk;
  logic             firstBusy, secondBusy, repAny, okA, okB;
  logic [3:0]       firstH, firstV, secondH, secondV, firstCnt, secondCnt;
  logic [3:0]       freeA, freeB;
  logic [SW-1:0]    firstSlot, secondSlot, repSlot, slotForA, slotForB;

  // Per-slot tick events, blast-report candidates and freed-owner tallies
  always_comb begin
    idleMask = '0;
    newBlast = '0;
    freeMask = '0;
    freeA    = 4'd0;
    freeB    = 4'd0;
    repSlot  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      idleMask[i] = (slotState[i] == IDLE);
      newBlast[i] = tick && (slotState[i] == ARMED) && (slotCnt[i] == 4'd1);
      freeMask[i] = tick && (slotState[i] == BLAST) && (slotCnt[i] == 4'd1);
      freeA = freeA + {3'd0, freeMask[i] & ~slotOwner[i]};
      freeB = freeB + {3'd0, freeMask[i] & slotOwner[i]};
    end
    candMask = pend | newBlast;
    repAny   = |candMask;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      repSlot = candMask[i] ? SW'(i) : repSlot;
    end
  end

  // Two-stage arbitration: the priority player sees registered state, the
  // other also sees the first player's grant (slot taken, tile occupied)
  always_comb begin
    firstReq   = prioB ? reqB : reqA;
    firstH     = prioB ? hB : hA;
    firstV     = prioB ? vB : vA;
    firstCnt   = prioB ? bCount : aCount;
    secondReq  = prioB ? reqA : reqB;
    secondH    = prioB ? hA : hB;
    secondV    = prioB ? vA : vB;
    secondCnt  = prioB ? aCount : bCount;
    firstBusy  = 1'b0;
    secondBusy = 1'b0;
    firstSlot  = '0;
    secondSlot = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      firstSlot  = idleMask[i] ? SW'(i) : firstSlot;
      firstBusy  = firstBusy  | (!idleMask[i] && slotH[i] == firstH  && slotV[i] == firstV);
      secondBusy = secondBusy | (!idleMask[i] && slotH[i] == secondH && slotV[i] == secondV);
    end
    firstOk = firstReq && (firstCnt < MAXC) && (|idleMask) && !firstBusy;
    for (int i = 0; i < NSLOT; i++) begin
      idle2[i] = idleMask[i] && !(firstOk && firstSlot == SW'(i));
    end
    for (int i = NSLOT - 1; i >= 0; i--) begin
      secondSlot = idle2[i] ? SW'(i) : secondSlot;
    end
    secondOk = secondReq && (secondCnt < MAXC) && (|idle2) && !secondBusy
               && !(firstOk && firstH == secondH && firstV == secondV);
    okA      = prioB ? secondOk : firstOk;
    okB      = prioB ? firstOk : secondOk;
    slotForA = prioB ? secondSlot : firstSlot;
    slotForB = prioB ? firstSlot : secondSlot;
  end

  // Slot state, ownership counts, priority and registered handshake/report outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        slotState[i] <= IDLE;
        slotH[i]     <= 4'd0;
        slotV[i]     <= 4'd0;
        slotCnt[i]   <= 4'd0;
      end
      slotOwner  <= '0;
      pend       <= '0;
      prioB      <= 1'b0;
      aCount     <= 4'd0;
      bCount     <= 4'd0;
      grantA     <= 1'b0;
      grantB     <= 1'b0;
      denyA      <= 1'b0;
      denyB      <= 1'b0;
      blastValid <= 1'b0;
      blastH     <= 4'd0;
      blastV     <= 4'd0;
      blastOwner <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (okA && slotForA == SW'(i)) begin
          slotState[i] <= ARMED;
          slotOwner[i] <= 1'b0;
          slotH[i]     <= hA;
          slotV[i]     <= vA;
          slotCnt[i]   <= FUSE_INIT;
        end else if (okB && slotForB == SW'(i)) begin
          slotState[i] <= ARMED;
          slotOwner[i] <= 1'b1;
          slotH[i]     <= hB;
          slotV[i]     <= vB;
          slotCnt[i]   <= FUSE_INIT;
        end else if (newBlast[i]) begin
          slotState[i] <= BLAST;
          slotCnt[i]   <= BLAST_INIT;
        end else if (freeMask[i]) begin
          slotState[i] <= IDLE;
          slotCnt[i]   <= 4'd0;
        end else if (tick && slotState[i] != IDLE) begin
          slotCnt[i]   <= slotCnt[i] - 4'd1;
        end
        pend[i] <= candMask[i] && (repSlot != SW'(i));
      end
      prioB      <= (reqA && reqB) ? !prioB : prioB;
      aCount     <= aCount + {3'd0, okA} - freeA;
      bCount     <= bCount + {3'd0, okB} - freeB;
      grantA     <= okA;
      grantB     <= okB;
      denyA      <= reqA && !okA;
      denyB      <= reqB && !okB;
      blastValid <= repAny;
      blastH     <= repAny ? slotH[repSlot] : 4'd0;
      blastV     <= repAny ? slotV[repSlot] : 4'd0;
      blastOwner <= repAny ? slotOwner[repSlot] : 1'b0;
    end
  end

  // Live-blast view decoded straight from slot state flops
  always_comb begin
    liveMask = '0;
    for (int i = 0; i < NSLOT; i++) begin
      liveMask[i] = (slotState[i] == BLAST);
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Table-driven bench for bomb_scheduler: per-cycle vectors with hand-derived
// expectations routed through a scoreboard queue, plus reset sequences.
module tb_bomb_scheduler;

  localparam int NV = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, reqA, reqB;
  logic [3:0] hA, vA, hB, vB;
  logic       grantA, grantB, denyA, denyB;
  logic [3:0] aCount, bCount;
  logic       blastValid, blastOwner;
  logic [3:0] blastH, blastV;
  logic [3:0] liveMask;

  bomb_scheduler #(.NSLOT(4), .FUSE_TICKS(3), .BLAST_TICKS(2), .MAXPER(2)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .reqA(reqA), .reqB(reqB), .hA(hA), .vA(vA), .hB(hB), .vB(vB),
    .grantA(grantA), .grantB(grantB), .denyA(denyA), .denyB(denyB),
    .aCount(aCount), .bCount(bCount),
    .blastValid(blastValid), .blastH(blastH), .blastV(blastV), .blastOwner(blastOwner),
    .liveMask(liveMask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ra;
    logic [3:0] ha, va;
    logic       rb;
    logic [3:0] hb, vb;
    logic       tk;
    logic       ga, da, gb, db;
    logic [3:0] ac, bc;
    logic       bl;
    logic [3:0] bh, bv;
    logic       bo;
    logic [3:0] lm;
  } vec_t;

  vec_t vecs [NV];
  vec_t expQ [$];
  int   passCnt  = 0;
  int   totalCnt = 0;

  function automatic vec_t mk(input int ra, ha, va, rb, hb, vb, tk,
                              ga, da, gb, db, ac, bc, bl, bh, bv, bo, lm);
    vec_t v;
    v.ra = 1'(ra); v.ha = 4'(ha); v.va = 4'(va);
    v.rb = 1'(rb); v.hb = 4'(hb); v.vb = 4'(vb);
    v.tk = 1'(tk);
    v.ga = 1'(ga); v.da = 1'(da); v.gb = 1'(gb); v.db = 1'(db);
    v.ac = 4'(ac); v.bc = 4'(bc);
    v.bl = 1'(bl); v.bh = 4'(bh); v.bv = 4'(bv); v.bo = 1'(bo);
    v.lm = 4'(lm);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic applyVec(input vec_t v, input string tag);
    vec_t e;
    reqA = v.ra; hA = v.ha; vA = v.va;
    reqB = v.rb; hB = v.hb; vB = v.vb;
    tick = v.tk;
    expQ.push_back(v);
    @(posedge clk);
    #1;
    reqA = 1'b0; reqB = 1'b0; tick = 1'b0;
    e = expQ.pop_front();
    chk({tag, " ctl"},
        32'({grantA, denyA, grantB, denyB, aCount, bCount, blastValid, liveMask}),
        32'({e.ga, e.da, e.gb, e.db, e.ac, e.bc, e.bl, e.lm}));
    if (e.bl) chk({tag, " blast"}, 32'({blastH, blastV, blastOwner}), 32'({e.bh, e.bv, e.bo}));
  endtask

  task automatic chkZero(input string tag);
    chk({tag, " ctl"},
        32'({grantA, denyA, grantB, denyB, aCount, bCount, blastValid, liveMask}), 32'd0);
    chk({tag, " blast"}, 32'({blastH, blastV, blastOwner}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    //              ra ha va rb hb vb tk  ga da gb db ac bc bl bh bv bo lm
    vecs[0]  = mk(1, 2, 3, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 1, 2, 3, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 4, 1, 1, 4, 1, 0,  1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 5, 1, 1, 5, 1, 0,  0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 4, 1, 0,  0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 6, 6, 0, 0, 0, 0,  1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 7, 7, 0, 0, 0, 0,  0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 7, 7, 0,  0, 0, 1, 0, 2, 2, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 1, 9, 9, 0,  0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 2, 1, 4, 1, 0, 15);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 1, 5, 1, 1, 15);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 1, 6, 6, 0, 15);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 1, 7, 7, 1, 15);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 15);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 15);
    vecs[22] = mk(1, 1, 1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[28] = mk(1, 3, 3, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 1, 3, 3, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[30] = mk(1, 8, 8, 1, 9, 9, 0,  1, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0);
    vecs[31] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);

    reqA = 1'b0; reqB = 1'b0; tick = 1'b0;
    hA = 4'd0; vA = 4'd0; hB = 4'd0; vB = 4'd0;
    rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chkZero("reset");
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-fuse with three armed bombs: nothing may survive or report
    rst = 1'b0;
    #1;
    chkZero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyVec(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               $sformatf("postrst_tick%0d", k));
    end
    // Priority must be back at A after reset
    applyVec(mk(1, 2, 2, 1, 2, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "postrst_prio");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
